// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_ctrl
// Brief    : SPI command decoder driving auto-incrementing register reads and
//            writes, keeping the byte interface's transmit byte preloaded.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
    parameter int          AW          = 7,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5,
    parameter int          DRAIN       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ss,
    input  logic          rx_valid,
    input  logic [7:0]    rx,
    output logic [7:0]    tx,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    byte_count
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CMD   = 3'd1;
    localparam logic [2:0] c_WRITE = 3'd2;
    localparam logic [2:0] c_READ  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    localparam int            c_CW         = $clog2(DRAIN + 1);
    localparam logic [c_CW-1:0] c_DRAIN_LOAD = c_CW'(DRAIN - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
    localparam logic [AW-1:0] c_ADDR_ONE   = AW'(1);

    logic [2:0]      r_ss_sync;
    logic [2:0]      r_state;
    logic [2:0]      r_pre;
    logic [c_CW-1:0] r_drain_cnt;
    logic            r_restart;
    logic            r_rd_wait;
    logic [AW-1:0]   r_addr;

    logic            w_ss_fall;
    logic            w_ss_rise;
    logic [2:0]      w_eff;
    logic            w_acc;
    logic [2:0]      w_mode_nxt;
    logic            w_drain_done;
    logic [AW-1:0]   w_cmd_addr;

    assign w_ss_fall  = r_ss_sync[2] & ~r_ss_sync[1];
    assign w_ss_rise  = ~r_ss_sync[2] & r_ss_sync[1];
    assign w_cmd_addr = rx[AW-1:0];

    // Late bytes arriving in DRAIN follow the rules of the state DRAIN was entered from.
    always_comb begin
        w_eff        = (r_state == c_DRAIN) ? r_pre : r_state;
        w_acc        = rx_valid && ((w_eff == c_CMD) || (w_eff == c_WRITE) || (w_eff == c_READ));
        w_mode_nxt   = w_eff;
        if (w_acc && (w_eff == c_CMD)) begin
            w_mode_nxt = rx[7] ? c_READ : c_WRITE;
        end
        w_drain_done = (r_state == c_DRAIN) && (r_drain_cnt == c_CNT_ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_sync   <= 3'b111;
            r_state     <= c_IDLE;
            r_pre       <= c_CMD;
            r_drain_cnt <= '0;
            r_restart   <= 1'b0;
            r_rd_wait   <= 1'b0;
            r_addr      <= '0;
            tx          <= STATUS_BYTE;
            reg_addr    <= '0;
            reg_wdata   <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            byte_count  <= 8'h00;
        end else begin
            r_ss_sync  <= {r_ss_sync[1:0], ss};
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            frame_done <= 1'b0;
            // A newly accepted byte cancels any read still in flight.
            r_rd_wait  <= reg_re && !w_acc;
            if (r_rd_wait && !w_acc) begin
                tx <= reg_rdata;
            end

            if (w_acc) begin
                if (byte_count != 8'hFF) begin
                    byte_count <= byte_count + 8'd1;
                end
                case (w_eff)
                    c_CMD: begin
                        if (rx[7]) begin
                            reg_re   <= 1'b1;
                            reg_addr <= w_cmd_addr;
                            r_addr   <= w_cmd_addr + c_ADDR_ONE;
                        end else begin
                            r_addr   <= w_cmd_addr;
                            tx       <= rx;
                        end
                    end
                    c_WRITE: begin
                        reg_we    <= 1'b1;
                        reg_addr  <= r_addr;
                        reg_wdata <= rx;
                        tx        <= rx;
                        r_addr    <= r_addr + c_ADDR_ONE;
                    end
                    default: begin
                        reg_re   <= 1'b1;
                        reg_addr <= r_addr;
                        r_addr   <= r_addr + c_ADDR_ONE;
                    end
                endcase
            end

            case (r_state)
                c_IDLE: begin
                    if (w_ss_fall) begin
                        r_state    <= c_CMD;
                        byte_count <= 8'h00;
                        busy       <= 1'b1;
                    end
                end
                c_CMD, c_WRITE, c_READ: begin
                    if (w_ss_rise) begin
                        r_state     <= c_DRAIN;
                        r_pre       <= w_mode_nxt;
                        r_drain_cnt <= c_DRAIN_LOAD;
                        r_restart   <= 1'b0;
                    end else begin
                        r_state <= w_mode_nxt;
                    end
                end
                c_DRAIN: begin
                    r_pre <= w_mode_nxt;
                    if (w_ss_fall) begin
                        r_restart <= 1'b1;
                    end else if (w_ss_rise) begin
                        r_restart <= 1'b0;
                    end
                    if (w_drain_done) begin
                        frame_done <= 1'b1;
                        tx         <= STATUS_BYTE;
                        r_rd_wait  <= 1'b0;
                        if (r_restart || w_ss_fall) begin
                            r_state    <= c_CMD;
                            byte_count <= 8'h00;
                            busy       <= 1'b1;
                        end else begin
                            r_state <= c_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_ctrl
// Brief    : Directed frame-level bench for spi_reg_ctrl with a register bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    localparam int c_DRAIN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic       rx_valid;
    logic [7:0] rx;
    logic [7:0] tx;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_done;
    logic [7:0] byte_count;

    spi_reg_ctrl #(.AW(7), .STATUS_BYTE(8'hA5), .DRAIN(c_DRAIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .rx_valid   (rx_valid),
        .rx         (rx),
        .tx         (tx),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .frame_done (frame_done),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // Register bank: read data returned the cycle after reg_re.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
    end

    logic [6:0] q_addr [$];
    logic [7:0] q_data [$];
    logic       q_wr   [$];
    int         fd_cnt  = 0;
    int         overlap = 0;
    always @(negedge clk) begin
        if (reg_we) begin q_addr.push_back(reg_addr); q_data.push_back(reg_wdata); q_wr.push_back(1'b1); end
        if (reg_re) begin q_addr.push_back(reg_addr); q_data.push_back(8'h00);     q_wr.push_back(1'b0); end
        if (reg_we && reg_re) overlap++;
        if (frame_done) fd_cnt++;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        q_addr.delete(); q_data.delete(); q_wr.delete();
    endtask

    task automatic run_frame(input int n, input logic [0:3][7:0] b, output logic [0:3][7:0] m);
        m  = '0;
        ss = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            m[i]     = tx;
            rx       = b[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            repeat (15) @(posedge clk);
            #1;
        end
        ss = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!frame_done && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic chk_access(input string nm, input int idx, input logic wr,
                              input logic [6:0] a, input logic [7:0] d);
        if (idx >= q_addr.size()) begin
            chk({nm, "_present"}, 32'(q_addr.size()), 32'(idx + 1));
        end else begin
            chk({nm, "_kind"}, 32'(q_wr[idx]), 32'(wr));
            chk({nm, "_addr"}, 32'(q_addr[idx]), 32'(a));
            if (wr) chk({nm, "_data"}, 32'(q_data[idx]), 32'(d));
        end
    endtask

    typedef struct packed {
        logic [2:0]      n;
        logic [0:3][7:0] b;
        logic [0:3][7:0] miso;
        logic [2:0]      nacc;
        logic            is_wr;
        logic [0:3][6:0] aaddr;
        logic [0:3][7:0] adata;
        logic [7:0]      bc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:3][7:0] m;
        int              cyc;
        int              fd0;

        vecs[0] = '{n: 3'd4, b: {8'h05, 8'h11, 8'h22, 8'h33}, miso: {8'hA5, 8'h05, 8'h11, 8'h22},
                    nacc: 3'd3, is_wr: 1'b1, aaddr: {7'h05, 7'h06, 7'h07, 7'h00},
                    adata: {8'h11, 8'h22, 8'h33, 8'h00}, bc: 8'd4};
        vecs[1] = '{n: 3'd3, b: {8'h90, 8'h00, 8'h00, 8'h00}, miso: {8'hA5, 8'hDE, 8'hAD, 8'h00},
                    nacc: 3'd3, is_wr: 1'b0, aaddr: {7'h10, 7'h11, 7'h12, 7'h00},
                    adata: '0, bc: 8'd3};
        vecs[2] = '{n: 3'd3, b: {8'h7F, 8'hAA, 8'hBB, 8'h00}, miso: {8'hA5, 8'h7F, 8'hAA, 8'h00},
                    nacc: 3'd2, is_wr: 1'b1, aaddr: {7'h7F, 7'h00, 7'h00, 7'h00},
                    adata: {8'hAA, 8'hBB, 8'h00, 8'h00}, bc: 8'd3};
        vecs[3] = '{n: 3'd3, b: {8'hFF, 8'h00, 8'h00, 8'h00}, miso: {8'hA5, 8'hAA, 8'hBB, 8'h00},
                    nacc: 3'd3, is_wr: 1'b0, aaddr: {7'h7F, 7'h00, 7'h01, 7'h00},
                    adata: '0, bc: 8'd3};
        vecs[4] = '{n: 3'd4, b: {8'h85, 8'h00, 8'h00, 8'h00}, miso: {8'hA5, 8'h11, 8'h22, 8'h33},
                    nacc: 3'd4, is_wr: 1'b0, aaddr: {7'h05, 7'h06, 7'h07, 7'h08},
                    adata: '0, bc: 8'd4};

        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[16] = 8'hDE;
        mem[17] = 8'hAD;

        rst = 1'b1; ss = 1'b1; rx_valid = 1'b0; rx = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx",         32'(tx), 32'h A5);
        chk("reset_busy",       32'(busy), 32'd0);
        chk("reset_byte_count", 32'(byte_count), 32'd0);
        chk("reset_strobes",    32'({reg_we, reg_re, frame_done}), 32'd0);
        chk("reset_reg_addr",   32'(reg_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            clear_q();
            fd0 = fd_cnt;
            run_frame(int'(vecs[v].n), vecs[v].b, m);
            wait_done(40, cyc);
            chk($sformatf("v%0d_frame_done_seen", v), 32'(frame_done), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            for (int i = 0; i < int'(vecs[v].n); i++)
                chk($sformatf("v%0d_miso%0d", v, i), 32'(m[i]), 32'(vecs[v].miso[i]));
            chk($sformatf("v%0d_byte_count", v), 32'(byte_count), 32'(vecs[v].bc));
            chk($sformatf("v%0d_n_access", v), 32'(q_addr.size()), 32'(vecs[v].nacc));
            for (int i = 0; i < int'(vecs[v].nacc); i++)
                chk_access($sformatf("v%0d_acc%0d", v, i), i, vecs[v].is_wr,
                           vecs[v].aaddr[i], vecs[v].adata[i]);
            chk($sformatf("v%0d_frame_done_count", v), 32'(fd_cnt - fd0), 32'd1);
            chk($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_tx_idle", v), 32'(tx), 32'hA5);
        end

        // Late byte: rx_valid two cycles after the synchronized rising edge.
        clear_q();
        ss = 1'b0;
        repeat (8) @(posedge clk); #1;
        rx = 8'h20; rx_valid = 1'b1; @(posedge clk); #1; rx_valid = 1'b0;
        repeat (15) @(posedge clk); #1;
        rx = 8'h44; rx_valid = 1'b1; @(posedge clk); #1; rx_valid = 1'b0;
        repeat (15) @(posedge clk); #1;
        ss = 1'b1;
        repeat (4) @(posedge clk); #1;
        rx = 8'h55; rx_valid = 1'b1; @(posedge clk); #1; rx_valid = 1'b0;
        wait_done(40, cyc);
        chk("late_frame_done_latency", 32'(cyc + 5), 32'(2 + c_DRAIN));
        repeat (3) @(posedge clk); #1;
        chk("late_n_access", 32'(q_addr.size()), 32'd2);
        chk_access("late_acc0", 0, 1'b1, 7'h20, 8'h44);
        chk_access("late_acc1", 1, 1'b1, 7'h21, 8'h55);
        chk("late_byte_count", 32'(byte_count), 32'd3);

        // Empty frame, then a new frame that starts while still draining.
        clear_q();
        fd0 = fd_cnt;
        ss = 1'b0;
        repeat (8) @(posedge clk); #1;
        ss = 1'b1;
        repeat (3) @(posedge clk); #1;
        ss = 1'b0;
        wait_done(40, cyc);
        chk("empty_frame_done_seen", 32'(frame_done), 32'd1);
        @(posedge clk); #1;
        chk("b2b_busy_restart", 32'(busy), 32'd1);
        chk("b2b_byte_count_clear", 32'(byte_count), 32'd0);
        chk("empty_no_access", 32'(q_addr.size()), 32'd0);
        run_frame(2, {8'h30, 8'h66, 8'h00, 8'h00}, m);
        wait_done(40, cyc);
        repeat (3) @(posedge clk); #1;
        chk("b2b_miso0", 32'(m[0]), 32'hA5);
        chk("b2b_miso1", 32'(m[1]), 32'h30);
        chk("b2b_n_access", 32'(q_addr.size()), 32'd1);
        chk_access("b2b_acc0", 0, 1'b1, 7'h30, 8'h66);
        chk("b2b_byte_count", 32'(byte_count), 32'd2);
        chk("b2b_frame_done_count", 32'(fd_cnt - fd0), 32'd2);

        // Reset in the cycle after reg_re of a read command.
        ss = 1'b0;
        repeat (8) @(posedge clk); #1;
        rx = 8'h90; rx_valid = 1'b1; @(posedge clk); #1; rx_valid = 1'b0;
        chk("rstrd_re_issued", 32'(reg_re), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; ss = 1'b1;
        @(posedge clk); #1;
        chk("rstrd_tx", 32'(tx), 32'hA5);
        chk("rstrd_strobes", 32'({reg_we, reg_re}), 32'd0);
        chk("rstrd_busy", 32'(busy), 32'd0);
        chk("rstrd_byte_count", 32'(byte_count), 32'd0);
        chk("rstrd_reg_addr", 32'(reg_addr), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("rstrd_tx_discarded", 32'(tx), 32'hA5);
        clear_q();
        run_frame(2, {8'h40, 8'h77, 8'h00, 8'h00}, m);
        wait_done(40, cyc);
        repeat (3) @(posedge clk); #1;
        chk("post_rst_miso1", 32'(m[1]), 32'h40);
        chk("post_rst_n_access", 32'(q_addr.size()), 32'd1);
        chk_access("post_rst_acc0", 0, 1'b1, 7'h40, 8'h77);

        chk("we_re_exclusive", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command/register-access controller that sits between the SPI slave byte interface and the design's control/status register bank (PID gains, setpoints, plate angles, ball position). It watches the slave-select line to frame transactions. It decodes the first byte of each frame as a command (read/write plus start address) and turns the following bytes into auto-incrementing register writes or prefetched register reads. It keeps the byte interface's transmit byte loaded so every outgoing byte is ready before its first SCLK falling edge.

## Interface
- AW, 7: register address width; command byte carries address in bits [AW-1:0], AW ≤ 7.
- STATUS_BYTE, 8'hA5: byte presented on tx while idle, i.e. shifted out during the command byte.
- DRAIN, 4: clk cycles after detected SS rising edge during which late rx_valid pulses are still accepted.

- clk  in  1  system clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- ss  in  1  raw SPI slave select, active low, asynchronous to clk.
- rx_valid  in  1  one-cycle pulse from byte interface: rx holds a new byte.
- rx  in  8  received byte.
- tx  out  8  byte the byte interface loads at the start of the next SPI byte.
- reg_addr  out  AW  register bank address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe; bank returns reg_rdata on the following cycle.
- reg_rdata  in  8  read data, valid one cycle after reg_re.
- busy  out  1  high from frame start through end of drain.
- frame_done  out  1  one-cycle pulse at end of drain.
- byte_count  out  8  bytes accepted in current/last frame, saturating at 255.

## Operation
- ss passes through 3-stage synchronizer; falling/rising edges are detected on stages [2:1], the same alignment as the byte interface.
- States: IDLE, CMD, WRITE, READ, DRAIN.
- IDLE: tx = STATUS_BYTE. ss falling -> CMD; byte_count cleared; busy=1.
- CMD, on rx_valid: latch addr = rx[AW-1:0], byte_count+1.
  - rx[7]=0 -> WRITE; tx = rx (echo).
  - rx[7]=1 -> READ; issue reg_re at addr, then load tx from reg_rdata and increment addr.
- WRITE, on rx_valid: reg_we with reg_addr=addr, reg_wdata=rx; tx = rx; addr+1; byte_count+1.
- READ, on rx_valid (the master's dummy byte is ignored): reg_re at addr; tx = reg_rdata; addr+1; byte_count+1.
- Address arithmetic is modulo 2^AW: address 2^AW-1 increments to 0.
- ss rising in CMD/WRITE/READ -> DRAIN. rx_valid during DRAIN is processed with the pre-DRAIN state's rules; the state then remains DRAIN. After DRAIN cycles: frame_done pulse, busy=0, tx = STATUS_BYTE, -> IDLE.
- ss falling during DRAIN: finish the drain, then enter CMD directly; byte_count is cleared on entry.
- A frame with zero bytes (ss low then high, no rx_valid) produces no register access but still pulses frame_done.
- rst at any time: state IDLE, all strobes deasserted immediately on the next edge, addr=0, byte_count=0, busy=0, frame_done=0, tx=STATUS_BYTE, reg_addr=0, reg_wdata=0. An in-flight read is discarded.

## Timing
- rx_valid at cycle T: reg_we/reg_re and reg_addr/reg_wdata registered, asserted at T+1.
- Read: reg_rdata sampled at T+2; tx valid at T+3. Write/echo: tx valid at T+1.
- Command read: first data byte on tx by T+3 after the command rx_valid.
- Requirement on system: SCLK period ≥ 16 clk cycles. This leaves ≥3 cycles of margin between rx_valid and the next SCLK falling edge.
- reg_we and reg_re never assert in the same cycle; at most one access per rx_valid.
- rx_valid while the previous read is still pending (T+1..T+2) cannot occur under the SCLK requirement. If it does, the new byte wins and byte_count still increments.
- frame_done asserts DRAIN cycles after the synchronized ss rising edge is detected.

## Test plan
- Write burst: ss low; bytes 0x05, 0x11, 0x22, 0x33 -> reg_we at addr 5,6,7 with data 0x11,0x22,0x33; byte_count=4; MISO stream A5,05,11,22; frame_done once.
- Read burst: bank holds [0x10]=0xDE, [0x11]=0xAD; bytes 0x90, 0x00, 0x00 -> MISO A5,DE,AD; reg_re at addr 0x10 then 0x11, then 0x12 (prefetch); no reg_we.
- Wrap: write cmd 0x7F, data 0xAA, 0xBB -> writes to addr 0x7F then 0x00.
- Late byte: last SCLK edge immediately followed by ss high, so rx_valid lands 2 cycles after ss rising is detected -> write still performed; frame_done DRAIN cycles after the edge.
- Empty frame and back-to-back frames: ss low/high with no SCLK, then a new frame starting during DRAIN -> no accesses for the empty frame; the second frame's command decoded correctly; byte_count restarts at 0.
- Reset mid-read: assert rst in the cycle after reg_re -> tx=0xA5, reg_re/reg_we=0, state IDLE. A following write frame then works normally.
